// File: rtl/pulse_gen_pkg.sv
// Shared constants, channel state encoding and per-channel configuration
// record for the 16-channel pulse-burst generator.
package pulse_gen_pkg;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 16;
  localparam int PH_W   = 8;

  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1'b1);
  localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_HIGH = 2'd1,
    CH_LOW  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] num;
    logic [PH_W-1:0]  high;
    logic [PH_W-1:0]  low;
  } ch_cfg_t;

  // A zero-length phase is run as one cycle so every pulse has a visible edge.
  function automatic logic [PH_W-1:0] ph_len(input logic [PH_W-1:0] v);
    if (v == PH_ZERO) begin
      ph_len = PH_ONE;
    end else begin
      ph_len = v;
    end
  endfunction

endpackage

// File: rtl/pulse_burst_chan.sv
// One pulse-burst channel: HIGH/LOW phase FSM, phase and pulse counters,
// optional sent-pulse counter (built when PULSE_GEN_SENT_CNT_EN is defined).
// The FSM state runs one enabled edge ahead of the registered pulse output.
module pulse_burst_chan
  import pulse_gen_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_active,
  input  ch_cfg_t          i_cfg,
  input  logic             i_en,
  output logic             o_pulse,
  output logic             o_idle,
  output logic [CNT_W-1:0] o_sent_cnt
);

  ch_state_e        state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [PH_W-1:0]  high_q, high_d;
  logic [PH_W-1:0]  low_q, low_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;

  // Next-state logic: load on start, otherwise advance phases only when enabled.
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    high_d   = high_q;
    low_d    = low_q;
    rem_d    = rem_q;
    pulse_d  = pulse_q;
    if (i_en) begin
      pulse_d = (state_q == CH_HIGH);
    end else begin
      pulse_d = pulse_q;
    end
    if (i_load) begin
      high_d   = ph_len(i_cfg.high);
      low_d    = ph_len(i_cfg.low);
      ph_cnt_d = ph_len(i_cfg.high);
      rem_d    = i_cfg.num;
      if (i_active && (i_cfg.num != CNT_ZERO)) begin
        state_d = CH_HIGH;
      end else begin
        state_d = CH_IDLE;
      end
    end else if (i_en) begin
      case (state_q)
        CH_HIGH: begin
          if (ph_cnt_q == PH_ONE) begin
            state_d  = CH_LOW;
            ph_cnt_d = low_q;
          end else begin
            ph_cnt_d = ph_cnt_q - PH_ONE;
          end
        end
        CH_LOW: begin
          if (ph_cnt_q == PH_ONE) begin
            if (rem_q == CNT_ONE) begin
              state_d = CH_IDLE;
              rem_d   = CNT_ZERO;
            end else begin
              state_d  = CH_HIGH;
              rem_d    = rem_q - CNT_ONE;
              ph_cnt_d = high_q;
            end
          end else begin
            ph_cnt_d = ph_cnt_q - PH_ONE;
          end
        end
        CH_IDLE: begin
          state_d = CH_IDLE;
        end
        default: begin
          state_d = CH_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= CH_IDLE;
      ph_cnt_q <= PH_ZERO;
      high_q   <= PH_ZERO;
      low_q    <= PH_ZERO;
      rem_q    <= CNT_ZERO;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      rem_q    <= rem_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_idle  = (state_q == CH_IDLE);

`ifdef PULSE_GEN_SENT_CNT_EN
  logic [CNT_W-1:0] sent_q, sent_d;

  // Count rising edges of the output pulse, clear on load, saturate at all-ones.
  always_comb begin
    sent_d = sent_q;
    if (i_load) begin
      sent_d = CNT_ZERO;
    end else if (pulse_d && !pulse_q && (sent_q != CNT_MAX)) begin
      sent_d = sent_q + CNT_ONE;
    end else begin
      sent_d = sent_q;
    end
  end

  // Sent-pulse counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sent_q <= CNT_ZERO;
    end else begin
      sent_q <= sent_d;
    end
  end

  assign o_sent_cnt = sent_q;
`else
  assign o_sent_cnt = CNT_ZERO;
`endif

endmodule

// File: rtl/pulse_burst_gen16.sv
// 16-channel programmable pulse-burst generator top: config bank, start
// acceptance, busy/done handshake and NUM_CH channel instances.
// Optional feature macro: PULSE_GEN_SENT_CNT_EN (per-channel sent counters).
module pulse_burst_gen16
  import pulse_gen_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cfg_we,
  input  logic [3:0]              i_cfg_ch,
  input  logic [CNT_W-1:0]        i_cfg_num,
  input  logic [PH_W-1:0]         i_cfg_high,
  input  logic [PH_W-1:0]         i_cfg_low,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  input  logic                    i_start,
  input  logic                    i_en,
  output logic [NUM_CH-1:0]       o_pulse,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NUM_CH*CNT_W-1:0] o_sent_cnt
);

  ch_cfg_t [NUM_CH-1:0] cfg_q, cfg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_acc_s;
  logic [NUM_CH-1:0]    chan_idle_s;
  logic                 all_idle_s;

  assign start_acc_s = i_start && !busy_q;
  assign all_idle_s  = &chan_idle_s;

  // Config bank write, dropped while a burst is running.
  always_comb begin
    cfg_d = cfg_q;
    if (i_cfg_we && !busy_q) begin
      cfg_d[i_cfg_ch].num  = i_cfg_num;
      cfg_d[i_cfg_ch].high = i_cfg_high;
      cfg_d[i_cfg_ch].low  = i_cfg_low;
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Busy/done handshake: burst ends on the first cycle every channel is idle.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_acc_s) begin
      busy_d = 1'b1;
    end else if (busy_q && all_idle_s) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else begin
      busy_d = busy_q;
    end
  end

  // Config bank and handshake registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cfg_q  <= {NUM_CH{ch_cfg_t'({(CNT_W+2*PH_W){1'b0}})}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pulse_burst_chan u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (start_acc_s),
      .i_active   (i_ch_mask[g]),
      .i_cfg      (cfg_q[g]),
      .i_en       (i_en),
      .o_pulse    (o_pulse[g]),
      .o_idle     (chan_idle_s[g]),
      .o_sent_cnt (o_sent_cnt[g*CNT_W +: CNT_W])
    );
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_pulse_burst_gen16.sv
// Directed self-checking bench for pulse_burst_gen16.
module tb_pulse_burst_gen16;

`ifdef PULSE_GEN_SENT_CNT_EN
  localparam bit SENT_EN = 1'b1;
`else
  localparam bit SENT_EN = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_cfg_we;
  logic [3:0]   i_cfg_ch;
  logic [15:0]  i_cfg_num;
  logic [7:0]   i_cfg_high;
  logic [7:0]   i_cfg_low;
  logic [15:0]  i_ch_mask;
  logic         i_start;
  logic         i_en;
  logic [15:0]  o_pulse;
  logic         o_busy;
  logic         o_done;
  logic [255:0] o_sent_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int rises [16];
  int frozen_err;
  logic [31:0] pat;
  int done_at, done_cnt;

  pulse_burst_gen16 dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_num(i_cfg_num), .i_cfg_high(i_cfg_high), .i_cfg_low(i_cfg_low),
    .i_ch_mask(i_ch_mask), .i_start(i_start), .i_en(i_en), .o_pulse(o_pulse),
    .o_busy(o_busy), .o_done(o_done), .o_sent_cnt(o_sent_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input int ch, input int n, input int h, input int l);
    i_cfg_we = 1'b1; i_cfg_ch = 4'(ch); i_cfg_num = 16'(n); i_cfg_high = 8'(h); i_cfg_low = 8'(l);
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] mask);
    i_ch_mask = mask; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Tick up to budget edges after the start edge; pattern of channel pch in pat.
  task automatic run_burst(input int budget, input int pch, input int freeze_at,
                           input int inject_at, input bit stop_at_done);
    logic [15:0] prev;
    bit frz;
    prev = o_pulse; pat = 32'h0; done_at = 0; done_cnt = 0; frozen_err = 0;
    for (int c = 0; c < 16; c++) rises[c] = 0;
    for (int k = 1; k <= budget; k++) begin
      if (k == inject_at) begin
        i_cfg_we = 1'b1; i_cfg_ch = 4'd0; i_cfg_num = 16'd1; i_cfg_high = 8'd1; i_cfg_low = 8'd1;
        i_start = 1'b1; i_ch_mask = 16'hFFFF;
      end
      frz = (freeze_at != 0) && (k > freeze_at) && (k <= freeze_at + 10);
      i_en = !frz;
      tick();
      i_cfg_we = 1'b0; i_start = 1'b0;
      for (int c = 0; c < 16; c++) if (o_pulse[c] && !prev[c]) rises[c]++;
      if (frz && (o_pulse != prev)) frozen_err++;
      if (k <= 32) pat[k-1] = o_pulse[pch];
      prev = o_pulse;
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        if (stop_at_done) break;
      end
    end
    i_en = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_ch = 4'd0; i_cfg_num = 16'd0; i_cfg_high = 8'd0;
    i_cfg_low = 8'd0; i_ch_mask = 16'h0; i_start = 1'b0; i_en = 1'b1;
    tick(); tick();
    check("rst_pulse", o_pulse, 16'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_sent", o_sent_cnt[63:0], 64'h0);
    i_rst_n = 1'b1;
    tick();

    // Test 1: ch0 N=3 H=2 L=3
    cfg_write(0, 3, 2, 3);
    do_start(16'h0001);
    check("t1_busy_after_start", o_busy, 1'b1);
    check("t1_pulse_after_start", o_pulse, 16'h0);
    run_burst(40, 0, 0, 0, 1'b1);
    check("t1_pattern", pat, 32'h0000_0C63);
    check("t1_done_at", done_at, 16);
    check("t1_busy_at_done", o_busy, 1'b0);
    check("t1_others_quiet", rises[1] + rises[15], 0);
    check("t1_sent0", o_sent_cnt[15:0], SENT_EN ? 16'd3 : 16'd0);
    tick();
    check("t1_done_one_cycle", o_done, 1'b0);

    // Test 2: all channels N=ch+1, H=1, L=1
    for (int c = 0; c < 16; c++) cfg_write(c, c + 1, 1, 1);
    do_start(16'hFFFF);
    run_burst(40, 15, 0, 0, 1'b0);
    check("t2_done_at", done_at, 33);
    check("t2_done_cnt", done_cnt, 1);
    for (int c = 0; c < 16; c++) check($sformatf("t2_rises_ch%0d", c), rises[c], c + 1);
    check("t2_ch15_pattern", pat, 32'h5555_5555);
    check("t2_sent15", o_sent_cnt[240 +: 16], SENT_EN ? 16'd16 : 16'd0);
    check("t2_sent7", o_sent_cnt[112 +: 16], SENT_EN ? 16'd8 : 16'd0);
    check("t2_busy_end", o_busy, 1'b0);

    // Test 3: freeze mid-burst for 10 cycles while ch0 is high
    cfg_write(0, 3, 2, 3);
    do_start(16'h0001);
    run_burst(60, 0, 1, 0, 1'b1);
    check("t3_frozen", frozen_err, 0);
    check("t3_done_at", done_at, 26);
    check("t3_rises0", rises[0], 3);

    // Test 4: cfg write and start while busy are dropped; back-to-back start
    do_start(16'h0001);
    run_burst(40, 0, 0, 2, 1'b1);
    check("t4_done_at", done_at, 16);
    check("t4_rises0", rises[0], 3);
    check("t4_rises1", rises[1], 0);
    check("t4_busy_done_cycle", o_busy, 1'b0);
    do_start(16'h0001);
    check("t4_b2b_busy", o_busy, 1'b1);
    check("t4_b2b_done_clear", o_done, 1'b0);
    run_burst(40, 0, 0, 0, 1'b1);
    check("t4_b2b_done_at", done_at, 16);
    check("t4_b2b_rises0", rises[0], 3);

    // Test 5: empty mask, then H=0/L=0 promoted to period 2
    do_start(16'h0000);
    check("t5_empty_busy", o_busy, 1'b1);
    check("t5_empty_done0", o_done, 1'b0);
    tick();
    check("t5_empty_done", o_done, 1'b1);
    check("t5_empty_busy_end", o_busy, 1'b0);
    check("t5_empty_pulse", o_pulse, 16'h0);
    tick();
    check("t5_empty_done_end", o_done, 1'b0);
    cfg_write(3, 2, 0, 0);
    do_start(16'h0008);
    run_burst(20, 3, 0, 0, 1'b1);
    check("t5_zero_ph_pattern", pat, 32'h0000_0005);
    check("t5_zero_ph_done_at", done_at, 5);

    // Test 6: reset mid-burst
    cfg_write(0, 3, 2, 3);
    do_start(16'h0001);
    tick();
    check("t6_pulse_before_rst", o_pulse[0], 1'b1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("t6_rst_pulse", o_pulse, 16'h0);
    check("t6_rst_busy", o_busy, 1'b0);
    check("t6_rst_done", o_done, 1'b0);
    check("t6_rst_sent", o_sent_cnt[15:0], 16'h0);
    run_burst(20, 0, 0, 0, 1'b0);
    check("t6_no_done_after_rst", done_cnt, 0);
    check("t6_no_pulse_after_rst", rises[0], 0);
    // Config bank cleared by reset: full mask still gives an empty burst.
    do_start(16'hFFFF);
    tick();
    check("t6_cfg_cleared_done", o_done, 1'b1);
    check("t6_cfg_cleared_pulse", o_pulse, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
